// File: rtl/count_reload_pkg.sv
// Shared types and default sizes for the counter reload sequencer.
package count_reload_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/preset_fifo.sv
// Small synchronous FIFO of counter presets; head is always visible on rdata.
module preset_fifo
    import count_reload_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LVLW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVLW-1:0]  level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wptr_reg;
    logic [AW:0]      rptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // The extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty   = (wptr_reg == rptr_reg);
    assign full    = (wptr_reg[AW] != rptr_reg[AW]) &&
                     (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign level   = LVLW'(wptr_reg - rptr_reg);
    assign rdata   = mem_reg[rptr_reg[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_reload_seq.sv
// Drives a loadable up counter so it reloads the next queued preset right after it reaches limit.
module count_reload_seq
    import count_reload_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LVLW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] count_in,
    output logic             load,
    output logic [WIDTH-1:0] data_out,
    output logic [LVLW-1:0]  fifo_level,
    output logic             underrun,
    input  logic             underrun_clr
);

    state_t           state_reg;
    state_t           state_next;
    logic             load_reg;
    logic             load_next;
    logic [WIDTH-1:0] data_out_reg;
    logic [WIDTH-1:0] data_out_next;
    logic             underrun_reg;
    logic             underrun_next;
    logic             underrun_set;

    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] limit_m1;
    logic             match;

    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;

    preset_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LVLW  (LVLW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Matching one below limit lets the registered load land on the count==limit cycle.
    assign limit_m1 = limit - WIDTH'(1);
    assign match    = (count_in == limit_m1);

    always_comb begin
        state_next    = state_reg;
        load_next     = 1'b0;
        data_out_next = data_out_reg;
        fifo_pop      = 1'b0;
        underrun_set  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_pop      = 1'b1;
                    data_out_next = fifo_head;
                    load_next     = 1'b1;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (match && !fifo_empty) begin
                    fifo_pop      = 1'b1;
                    data_out_next = fifo_head;
                    load_next     = 1'b1;
                    state_next    = LOAD;
                end else if (match) begin
                    underrun_set = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        underrun_next = underrun_reg;
        if (underrun_set) begin
            underrun_next = 1'b1;
        end else if (underrun_clr) begin
            underrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            load_reg     <= 1'b0;
            data_out_reg <= '0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            load_reg     <= load_next;
            data_out_reg <= data_out_next;
            underrun_reg <= underrun_next;
        end
    end

    assign load     = load_reg;
    assign data_out = data_out_reg;
    assign underrun = underrun_reg;

endmodule
